// File: rtl/phase_sweep_gen.sv
// -----------------------------------------------------------------------------
// phase_sweep_gen
//
// Phase-accumulator angle source for a CORDIC rotator. After a configuration
// handshake it runs a phase accumulator whose tuning word either sweeps
// linearly from a base to a limit (optionally looping) or holds a fixed tone.
// The top DW bits of the accumulator are the rotator angle.
//
// Parameters
//   DW  output angle width (rotator angle input width)
//   AW  accumulator / tuning-word width, AW >= DW+4
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-low reset
//   cfg_valid   in   configuration offer
//   cfg_ready   out  high only while idle
//   ftw_base    in   start tuning word (captured on handshake)
//   ftw_step    in   per-cycle tuning-word increment, 0 = fixed tone
//   ftw_limit   in   sweep end tuning word
//   loop        in   1 = restart at ftw_base after the limit is reached
//   stop        in   synchronous abort back to idle
//   ang         out  two's-complement angle, full scale = one turn
//   ang_valid   out  ang qualifier (rotator enable)
//   sweep_done  out  one-cycle pulse when the tuning word reaches the limit
//
// Build option
//   PHASE_SWEEP_DITHER_EN  when defined, a 16-bit Galois LFSR adds dither to
//                          the bits discarded by truncation; the accumulator
//                          itself is never dithered.
// -----------------------------------------------------------------------------
module phase_sweep_gen #(
    parameter int DW = 10,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [AW-1:0] ftw_base,
    input  logic [AW-1:0] ftw_step,
    input  logic [AW-1:0] ftw_limit,
    input  logic          loop,
    input  logic          stop,
    output logic [DW-1:0] ang,
    output logic          ang_valid,
    output logic          sweep_done
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SWEEP = 2'b01;
    localparam logic [1:0] ST_TONE  = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] ftw_q, ftw_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] step_q, step_d;
    logic [AW-1:0] limit_q, limit_d;
    logic          loop_q, loop_d;
    logic [DW-1:0] ang_q, ang_d;
    logic          ang_valid_q;
    logic          done_q, done_d;
    logic          active_d_s;
    logic [AW:0]   sum_s;
    logic [AW-1:0] ang_src_s;

    // Next-state logic for the FSM, accumulator, tuning word and captured config
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ftw_d   = ftw_q;
        base_d  = base_q;
        step_d  = step_q;
        limit_d = limit_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        // One extra bit so ftw + step can never wrap before the limit compare
        sum_s   = {1'b0, ftw_q} + {1'b0, step_q};
        case (state_q)
            ST_IDLE: begin
                // stop is deliberately ignored here: a handshake always wins
                if (cfg_valid) begin
                    base_d  = ftw_base;
                    step_d  = ftw_step;
                    limit_d = ftw_limit;
                    loop_d  = loop;
                    acc_d   = {AW{1'b0}};
                    ftw_d   = ftw_base;
                    if ((ftw_step != {AW{1'b0}}) && (ftw_base < ftw_limit)) begin
                        state_d = ST_SWEEP;
                    end else begin
                        state_d = ST_TONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_q + ftw_q;
                    if (sum_s >= {1'b0, limit_q}) begin
                        done_d = 1'b1;
                        if (loop_q) begin
                            ftw_d = base_q;
                        end else begin
                            ftw_d   = limit_q;
                            state_d = ST_TONE;
                        end
                    end else begin
                        ftw_d = sum_s[AW-1:0];
                    end
                end
            end
            ST_TONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_q + ftw_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign active_d_s = (state_d != ST_IDLE);

`ifdef PHASE_SWEEP_DITHER_EN
    localparam logic [AW-1:0] DITH_MASK =
        ({{(AW-1){1'b0}}, 1'b1} << (AW-DW)) - {{(AW-1){1'b0}}, 1'b1};

    logic [15:0]   lfsr_q, lfsr_d;
    logic [AW-1:0] dith_s;

    // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] sh;
        sh = {1'b0, s[15:1]};
        if (s[0]) begin
            lfsr_next = sh ^ 16'hB400;
        end else begin
            lfsr_next = sh;
        end
    endfunction

    // Dither only touches the bits below the angle LSB
    always_comb begin
        if (active_d_s) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
        dith_s    = AW'(lfsr_q) & DITH_MASK;
        ang_src_s = acc_d + dith_s;
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign ang_src_s = acc_d;
`endif

    // Angle holds its last value whenever the generator drops back to idle
    always_comb begin
        if (active_d_s) begin
            ang_d = ang_src_s[AW-1 -: DW];
        end else begin
            ang_d = ang_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= {AW{1'b0}};
            ftw_q       <= {AW{1'b0}};
            base_q      <= {AW{1'b0}};
            step_q      <= {AW{1'b0}};
            limit_q     <= {AW{1'b0}};
            loop_q      <= 1'b0;
            ang_q       <= {DW{1'b0}};
            ang_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_q       <= ftw_d;
            base_q      <= base_d;
            step_q      <= step_d;
            limit_q     <= limit_d;
            loop_q      <= loop_d;
            ang_q       <= ang_d;
            ang_valid_q <= active_d_s;
            done_q      <= done_d;
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign ang        = ang_q;
    assign ang_valid  = ang_valid_q;
    assign sweep_done = done_q;

endmodule

// File: doc/phase_sweep_gen.md
PHASE_SWEEP_GEN -- requirements
Module: phase_sweep_gen

Interface
REQ-001 Parameter DW, default 10, output angle width; matches the CORDIC rotator angle input.
REQ-002 Parameter AW, default 24, phase accumulator and tuning-word width; AW >= DW+4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
REQ-005 cfg_valid  input  1  configuration offer.
REQ-006 cfg_ready  output  1  high only in IDLE.
REQ-007 ftw_base  input  AW  unsigned start tuning word, captured on cfg handshake.
REQ-008 ftw_step  input  AW  unsigned per-cycle tuning-word increment, captured on cfg handshake; 0 means fixed tone.
REQ-009 ftw_limit  input  AW  unsigned sweep end tuning word, captured on cfg handshake.
REQ-010 loop  input  1  captured on cfg handshake; 1 = restart sweep at ftw_base after reaching limit.
REQ-011 stop  input  1  synchronous abort to IDLE.
REQ-012 ang  output  DW  signed phase, two's-complement, full scale = one turn; drives the rotator angle input.
REQ-013 ang_valid  output  1  ang qualifier; drives the rotator en.
REQ-014 sweep_done  output  1  one-cycle pulse when the tuning word reaches ftw_limit.

Function
REQ-015 States: IDLE, SWEEP, TONE; 2-bit encoded.
REQ-016 IDLE: cfg_ready=1; accumulator and ftw hold; ang_valid=0.
REQ-017 Handshake = cfg_valid & cfg_ready; on it, capture all config, clear accumulator, ftw<=ftw_base; go SWEEP if ftw_step!=0 and ftw_base<ftw_limit, else TONE.
REQ-018 SWEEP/TONE: each cycle acc <= acc + ftw, modulo 2^AW (wrap-around is the intended phase wrap, no saturation).
REQ-019 SWEEP: each cycle ftw <= ftw + ftw_step; if ftw + ftw_step >= ftw_limit (compare in AW+1 bits, no overflow), ftw <= ftw_limit, sweep_done pulses that cycle, next state TONE if loop=0, else ftw <= ftw_base and stay SWEEP.
REQ-020 TONE: ftw constant; runs until stop.
REQ-021 ang = acc[AW-1 -: DW], registered; ang_valid registered; one-cycle latency: ang in cycle n reflects acc after update in cycle n-1.
REQ-022 First valid ang after handshake is 0, ang_valid rising in the cycle after the handshake edge.
REQ-023 stop in SWEEP/TONE: next state IDLE, ang_valid=0 next cycle, ang holds last value, sweep_done suppressed.
REQ-024 stop and cfg_valid in the same IDLE cycle: handshake wins, stop ignored.
REQ-025 stop concurrent with limit hit: stop wins, no sweep_done.
REQ-026 cfg_valid outside IDLE is ignored; no config change mid-run.

Reset
REQ-027 rst low: state=IDLE, acc=0, ftw=0, all captured config=0, ang=0, ang_valid=0, sweep_done=0, cfg_ready=1 within the reset assertion, without a clock edge.
REQ-028 Reset mid-sweep aborts with no sweep_done pulse; first cycle after deassertion behaves as IDLE.

Configuration
REQ-029 Macro PHASE_SWEEP_DITHER_EN: when defined, a 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset, advances each active cycle) supplies the low AW-DW bits added to acc before truncation to ang; accumulator itself undithered.
REQ-030 Without PHASE_SWEEP_DITHER_EN: no LFSR logic, plain truncation per REQ-021.

Verification (DW=10, AW=24, dither off unless noted)
REQ-031 Reset: drive rst low mid-TONE, no clock -> ang=0, ang_valid=0, cfg_ready=1 immediately.
REQ-032 Tone: ftw_base=24'h004000, step=0 -> ang=0,1,2,...,511,-512,... one LSB per cycle, wraps after 1024 valid cycles.
REQ-033 Sweep: base=24'h004000, step=24'h004000, limit=24'h014000, loop=0 -> ftw 4000,8000,C000,10000,14000; sweep_done single pulse at cycle 4; then TONE at 24'h014000.
REQ-034 Loop: same with loop=1 -> sweep_done every 4 cycles, ftw returns to 24'h004000, never enters TONE until stop.
REQ-035 Abort/conflict: stop asserted the cycle limit is hit -> IDLE, no sweep_done; stop+cfg_valid in IDLE -> handshake accepted.
REQ-036 Dither: define PHASE_SWEEP_DITHER_EN, tone ftw=24'h000001 -> ang mean over 65536 cycles within 1 LSB of undithered ramp; LFSR state 16'hACE1 after reset.
